// File: rtl/adder_sched_pkg.sv
// Shared constants and types for the round-robin adder scheduler.
package adder_sched_pkg;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 32;
  localparam int OPS_W     = 16;

  // One-entry result buffer occupancy
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;
endpackage

// File: rtl/ripplecarryadder.sv
// Plain ripple-carry adder: {cout, sum} = a + b + cin, carry rippling LSB to MSB.
module ripplecarryadder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] c;

  assign c[0] = cin;

  // One full-adder cell per bit
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[WIDTH];
endmodule

// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one ripple-carry adder among NREQ requesters,
// with a single-entry registered result buffer on the output side.
module adder_rr_sched
  import adder_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  input  logic [NREQ-1:0]          req_cin,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_carry,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [OPS_W-1:0]         ops_done
);
  localparam int IDW = $clog2(NREQ);

  buf_state_e      state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic            carry_q, carry_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [OPS_W-1:0] ops_q, ops_d;

  logic            found;
  logic [IDW-1:0]  win;
  logic            can_issue;
  logic            issue;
  logic            rsp_fire;
  logic [WIDTH-1:0] op_a, op_b;
  logic            op_cin;
  logic [WIDTH-1:0] add_sum;
  logic            add_cout;

  // First valid requester at or after p, wrapping; MSB flags that one was found.
  // Walk offsets high to low so the smallest offset overwrites last and wins.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] p);
    logic [IDW:0] r;
    r = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(p) + k) % NREQ;
      if (v[idx]) r = {1'b1, IDW'(idx)};
    end
    return r;
  endfunction

  // Arbitration
  always_comb begin
    {found, win} = rr_pick(req_valid, ptr_q);
  end

  // Winner operand mux feeding the shared adder
  always_comb begin
    op_a   = req_a[win*WIDTH +: WIDTH];
    op_b   = req_b[win*WIDTH +: WIDTH];
    op_cin = req_cin[win];
  end

  ripplecarryadder #(.WIDTH(WIDTH)) u_add (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Buffer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Buffer next state: a new issue always lands FULL, otherwise a drain empties it
  always_comb begin
    state_d = state_q;
    if (issue)         state_d = FULL;
    else if (rsp_fire) state_d = EMPTY;
  end

  // Handshake outputs; ready is held low during reset so nothing is accepted
  always_comb begin
    rsp_valid = (state_q == FULL);
    can_issue = (state_q == EMPTY) || rsp_ready;
    rsp_fire  = rsp_valid && rsp_ready;
    issue     = found && can_issue;
    req_ready = '0;
    if (issue && !rst) req_ready[win] = 1'b1;
  end

  // Result data, pointer and consume counter next values
  always_comb begin
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    id_d    = id_q;
    ops_d   = ops_q;
    if (issue) begin
      sum_d   = add_sum;
      carry_d = add_cout;
      id_d    = win;
      ptr_d   = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
    end
    if (rsp_fire) ops_d = ops_q + 1'b1;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= '0;
      ops_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      id_q    <= id_d;
      ops_q   <= ops_d;
    end
  end

  assign rsp_sum   = sum_q;
  assign rsp_carry = carry_q;
  assign rsp_id    = id_q;
  assign ops_done  = ops_q;
endmodule

// File: tb/tb_adder_rr_sched.sv
// Directed bench for adder_rr_sched: vector table plus multi-cycle sequences.
module tb_adder_rr_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_carry;
  logic [1:0]            rsp_id;
  logic [15:0]           ops_done;

  adder_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_id(rsp_id),
    .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        carry;
  } vec_t;

  vec_t tbl[6];
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b, input logic cin);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_cin[i]              = cin;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    tbl[0] = '{2, 32'd3,        32'd10,       1'b1, 32'd14,       1'b0};
    tbl[1] = '{0, 32'hFFFFFFFF, 32'h0,        1'b1, 32'h0,        1'b1};
    tbl[2] = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
    tbl[3] = '{3, 32'h80000000, 32'h80000000, 1'b0, 32'h0,        1'b1};
    tbl[4] = '{2, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0};
    tbl[5] = '{1, 32'h7FFFFFFF, 32'h0,        1'b1, 32'h80000000, 1'b0};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b0;
    #12;
    chk("rst_ready", 64'(req_ready), 64'h0);
    rst = 1'b0;
    tick();
    chk("rst_valid", 64'(rsp_valid), 64'h0);
    chk("rst_sum",   64'(rsp_sum),   64'h0);
    chk("rst_carry", 64'(rsp_carry), 64'h0);
    chk("rst_id",    64'(rsp_id),    64'h0);
    chk("rst_ops",   64'(ops_done),  64'h0);
    rsp_ready = 1'b1;
    #1;
    chk("idle_ready", 64'(req_ready), 64'h0);

    // Table: issue one request, check result, then drain with nothing pending
    for (int i = 0; i < 6; i++) begin
      req_valid = '0;
      req_valid[tbl[i].id] = 1'b1;
      set_ops(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].cin);
      #1;
      chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(4'b1 << tbl[i].id));
      tick();
      req_valid = '0;
      chk($sformatf("v%0d_valid", i), 64'(rsp_valid), 64'h1);
      chk($sformatf("v%0d_sum", i),   64'(rsp_sum),   64'(tbl[i].sum));
      chk($sformatf("v%0d_carry", i), 64'(rsp_carry), 64'(tbl[i].carry));
      chk($sformatf("v%0d_id", i),    64'(rsp_id),    64'(tbl[i].id));
      tick();
      chk($sformatf("v%0d_drain", i), 64'(rsp_valid), 64'h0);
      chk($sformatf("v%0d_ops", i),   64'(ops_done),  64'(i + 1));
    end

    // Backpressure: fill with 1701, stall 5 cycles with requester 1 waiting
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    set_ops(0, 32'd1200, 32'd500, 1'b1);
    set_ops(1, 32'd5, 32'd6, 1'b0);
    tick();
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_ready", k), 64'(req_ready), 64'h0);
      chk($sformatf("bp%0d_sum", k),   64'(rsp_sum),   64'd1701);
      chk($sformatf("bp%0d_valid", k), 64'(rsp_valid), 64'h1);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    rsp_ready = 1'b0;
    chk("bp_next_valid", 64'(rsp_valid), 64'h1);
    chk("bp_next_sum",   64'(rsp_sum),   64'd11);
    chk("bp_next_id",    64'(rsp_id),    64'd1);
    chk("bp_ops",        64'(ops_done),  64'd7);

    // Asynchronous reset while FULL with ops_done=7
    req_valid = 4'b1100;
    set_ops(2, 32'd1, 32'd1, 1'b0);
    set_ops(3, 32'd2, 32'd2, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", 64'(rsp_valid), 64'h0);
    chk("ar_sum",   64'(rsp_sum),   64'h0);
    chk("ar_id",    64'(rsp_id),    64'h0);
    chk("ar_ops",   64'(ops_done),  64'h0);
    chk("ar_ready", 64'(req_ready), 64'h0);
    #1;
    rst = 1'b0;
    #1;
    chk("ar_first_grant", 64'(req_ready), 64'b0100);
    tick();
    chk("ar_first_id",  64'(rsp_id),  64'd2);
    chk("ar_first_sum", 64'(rsp_sum), 64'd2);

    // Round robin: all valid, continuous drain, grant 0,1,2,3,0
    req_valid = '0;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_ops(i, 32'(i * 100), 32'(i), 1'b0);
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (k < 5) chk($sformatf("rr%0d_grant", k), 64'(req_ready), 64'(4'b1 << (k % 4)));
      if (k > 0) begin
        chk($sformatf("rr%0d_valid", k), 64'(rsp_valid), 64'h1);
        chk($sformatf("rr%0d_id", k),    64'(rsp_id),    64'((k - 1) % 4));
        chk($sformatf("rr%0d_sum", k),   64'(rsp_sum),   64'(((k - 1) % 4) * 101));
      end
      tick();
    end

    // Counter wrap: stream single requester, one consume per cycle after the first
    req_valid = '0;
    do_reset();
    set_ops(0, 32'd1, 32'd2, 1'b0);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    repeat (65536) @(posedge clk);
    #1;
    chk("wrap_ffff", 64'(ops_done), 64'hFFFF);
    tick();
    chk("wrap_zero",  64'(ops_done),  64'h0);
    chk("wrap_valid", 64'(rsp_valid), 64'h1);
    chk("wrap_sum",   64'(rsp_sum),   64'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
